mux_n_amostrador: RTL

//  N-channel, BITS-wide registered multiplexer with sample-and-hold output.

---
 rtl/mux_n_amostrador.sv | 122 ++++++++++++
 1 files changed

// File: rtl/mux_n_amostrador.sv
// N-channel registered multiplexer with sample-and-hold output.
// Supports manual capture on request and round-robin scan with a fixed dwell per channel.
module mux_n_amostrador #(
    parameter int BITS  = 4,
    parameter int N     = 4,
    parameter int DWELL = 8,
    localparam int SELW = $clog2(N)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [N*BITS-1:0]   D,
    input  logic [SELW-1:0]     SEL,
    input  logic                LOAD,
    input  logic                MODE,
    output logic [BITS-1:0]     OUT,
    output logic [SELW-1:0]     CANAL,
    output logic                VALID,
    output logic                ERRO
);

    localparam int CNTW = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DWELL - 1);
    localparam logic [SELW-1:0] CANAL_LAST = SELW'(N - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
    localparam logic [1:0] ST_SCAN = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [BITS-1:0] out_q,   out_d;
    logic [SELW-1:0] canal_q, canal_d;
    logic [CNTW-1:0] cnt_q,   cnt_d;
    logic            valid_q, valid_d;
    logic            erro_q,  erro_d;

    logic [SELW-1:0] canal_nxt;
    logic [BITS-1:0] sel_data;
    logic [BITS-1:0] scan_data;
    logic            sel_ok;

    assign canal_nxt = (canal_q == CANAL_LAST) ? '0 : canal_q + 1'b1;
    assign sel_ok    = (int'(SEL) < N);

    // Explicit per-channel compare keeps an out-of-range SEL from indexing past D.
    always_comb begin
        sel_data  = '0;
        scan_data = '0;
        for (int k = 0; k < N; k++) begin
            if (SEL == SELW'(k))       sel_data  = D[k*BITS +: BITS];
            if (canal_nxt == SELW'(k)) scan_data = D[k*BITS +: BITS];
        end
    end

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
        state_d = state_q;
        out_d   = out_q;
        canal_d = canal_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        erro_d  = erro_q;

        if (MODE) begin
            // Scan has priority over LOAD; SEL and LOAD are ignored here.
            if (state_q != ST_SCAN) begin
                state_d = ST_SCAN;
                canal_d = '0;
                out_d   = D[BITS-1:0];
                valid_d = 1'b1;
                cnt_d   = '0;
            end else if (cnt_q == CNT_LAST) begin
                cnt_d   = '0;
                canal_d = canal_nxt;
                out_d   = scan_data;
                valid_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            if (state_q == ST_SCAN) begin
                state_d = ST_HOLD;
                cnt_d   = '0;
            end
            if (LOAD) begin
                state_d = ST_HOLD;
                if (sel_ok) begin
                    out_d   = sel_data;
                    canal_d = SEL;
                    erro_d  = 1'b0;
                    valid_d = 1'b1;
                end else begin
                    erro_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            out_q   <= '0;
            canal_q <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            erro_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register updates from pre-edge values.
            state_q <= state_d;
            out_q   <= out_d;
            canal_q <= canal_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            erro_q  <= erro_d;
        end
    end

    assign OUT   = out_q;
    assign CANAL = canal_q;
    assign VALID = valid_q;
    assign ERRO  = erro_q;

endmodule
